// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the fetch PC, issues requests to a
// one-cycle-latency instruction memory, buffers returned words with their PCs in
// a 2-entry FIFO and presents the head entry to Decode. Taken branches flush the
// buffer and discard any wrong-path response still outstanding.
//
// Handshake: a fetch is issued when imemRequest && imemGrant are both high in a
// cycle; its response arrives with imemValid exactly one cycle later. Decode
// consumes the head entry in any cycle where instructionValid && !stall and no
// branch is being taken.
module fetch_unit #(
    parameter int                  PC_WIDTH          = 48,
    parameter int                  INSTRUCTION_WIDTH = 48,
    parameter int                  PC_INCREMENT      = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branchTaken,
    input  logic [PC_WIDTH-1:0]          branchTarget,
    output logic                         imemRequest,
    output logic [PC_WIDTH-1:0]          imemAddress,
    input  logic                         imemGrant,
    input  logic                         imemValid,
    input  logic [INSTRUCTION_WIDTH-1:0] imemData,
    output logic                         instructionValid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          PC
);

    logic [PC_WIDTH-1:0]          r_fetch_pc;
    logic [INSTRUCTION_WIDTH-1:0] r_fifo_instr [2];
    logic [PC_WIDTH-1:0]          r_fifo_pc    [2];
    logic                         r_head;
    logic [1:0]                   r_count;
    logic                         r_inflight;
    logic [PC_WIDTH-1:0]          r_inflight_pc;
    logic                         r_drop;

    logic                         w_pop;
    logic                         w_grant;
    logic                         w_push;
    logic                         w_tail;
    logic [2:0]                   w_credit;

    // Outputs come straight from buffer registers, so imemData never reaches them
    // combinationally. An empty buffer presents the all-zero NOP.
    assign instructionValid = (r_count != 2'd0);
    assign instruction      = instructionValid ? r_fifo_instr[r_head] : '0;
    assign PC               = instructionValid ? r_fifo_pc[r_head] : '0;

    // A redirect flushes the buffer, so nothing is consumed in that cycle.
    assign w_pop = instructionValid && !stall && !branchTaken;

    // Slots already committed (buffered plus in flight) after this cycle's pop;
    // a new request is only made when a slot is guaranteed for its response.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign imemRequest = !reset && (branchTaken || (w_credit < 3'd2));
    assign imemAddress = branchTaken ? branchTarget : r_fetch_pc;
    assign w_grant     = imemRequest && imemGrant;

    // A response arriving in a redirect cycle belongs to the old path and is lost
    // with the flush; a response marked drop is discarded as well.
    assign w_push = imemValid && r_inflight && !r_drop && !branchTaken;
    assign w_tail = r_head ^ r_count[0];

    // Buffer occupancy and head pointer; redirect empties the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else if (branchTaken) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    // Buffer storage: write the returned word and its PC into the tail slot.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_instr[w_tail] <= imemData;
            r_fifo_pc[w_tail]    <= r_inflight_pc;
        end
    end

    // Fetch PC advances past each granted address, or takes an ungranted redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_grant) begin
            r_fetch_pc <= imemAddress + PC_WIDTH'(PC_INCREMENT);
        end else if (branchTaken) begin
            r_fetch_pc <= branchTarget;
        end
    end

    // Track the single outstanding request and the PC its response belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_grant) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= imemAddress;
        end else if (imemValid && r_inflight) begin
            r_inflight <= 1'b0;
        end
    end

    // Mark an old-path response that is still outstanding after a redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else if (branchTaken) begin
            r_drop <= r_inflight && !imemValid;
        end else if (imemValid && r_drop) begin
            r_drop <= 1'b0;
        end
    end

endmodule
